// File: rtl/ball_engine.sv
// Ball motion and collision engine: programmable step rate, one-brick-per-cycle
// collision scan, wall/paddle/brick reflection. Optional macro BALL_PADDLE_ANGLE_EN.
module ball_engine #(
    parameter int NUM_BRICKS   = 8,
    parameter int IDX_W        = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1,
    parameter int COORD_W      = 10,
    parameter int DELAY_W      = 25,
    parameter int BALL_SIZE    = 20,
    parameter int BRICK_W      = 58,
    parameter int BRICK_H      = 20,
    parameter int PADDLE_W     = 75,
    parameter int PADDLE_Y     = 458,
    parameter int FIELD_LEFT   = 134,
    parameter int FIELD_RIGHT  = 504,
    parameter int FIELD_TOP    = 0,
    parameter int FIELD_BOTTOM = 478,
    parameter int START_X      = 309,
    parameter int START_Y      = 438,
    parameter int MAX_DX       = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DELAY_W-1:0]            delay_done,
    input  logic [COORD_W-1:0]            paddle_x,
    input  logic [NUM_BRICKS*COORD_W-1:0] brick_x,
    input  logic [NUM_BRICKS*COORD_W-1:0] brick_y,
    input  logic [NUM_BRICKS-1:0]         bricks_exist,
    output logic [COORD_W-1:0]            x,
    output logic [COORD_W-1:0]            y,
    output logic                          hit_valid,
    output logic [IDX_W-1:0]              hit_idx,
    output logic                          lost
);
    localparam int CW  = COORD_W + 1;
    localparam int XSW = COORD_W + 2;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCAN, S_BOUNCE, S_LOST} state_t;

    state_t             state;
    logic [DELAY_W-1:0] delay;
    logic signed [3:0]  dx;
    logic               dy_dn;
    logic [IDX_W-1:0]   idx;
    logic               hit_seen;

    logic [CW-1:0]      xe, ye, cx, bx, by, pe;
    logic signed [XSW-1:0] xs;
    logic [COORD_W-1:0] x_step, y_step;
    logic               overlap, centre_in, bottom;
    logic signed [3:0]  mag, b_dx;
    logic               b_dy_dn;

    assign xe = {1'b0, x};
    assign ye = {1'b0, y};
    assign pe = {1'b0, paddle_x};
    assign cx = xe + CW'(BALL_SIZE / 2);
    assign bx = {1'b0, brick_x[int'(idx)*COORD_W +: COORD_W]};
    assign by = {1'b0, brick_y[int'(idx)*COORD_W +: COORD_W]};

    assign overlap = bricks_exist[idx] &&
                     (xe <= bx + CW'(BRICK_W - 1)) && (xe + CW'(BALL_SIZE - 1) >= bx) &&
                     (ye <= by + CW'(BRICK_H - 1)) && (ye + CW'(BALL_SIZE - 1) >= by);
    assign centre_in = (cx >= bx) && (cx <= bx + CW'(BRICK_W - 1));
    assign bottom    = (ye + CW'(BALL_SIZE - 1) >= CW'(FIELD_BOTTOM));

    // x step saturates: sign bit means underflow, bit COORD_W means overflow
    assign xs     = $signed({2'b00, x}) + XSW'(dx);
    assign x_step = xs[XSW-1] ? '0 : (xs[COORD_W] ? '1 : xs[COORD_W-1:0]);
    assign y_step = dy_dn ? y + 1'b1 : y - 1'b1;
    assign mag    = dx[3] ? -dx : dx;

`ifdef BALL_PADDLE_ANGLE_EN
    logic signed [3:0] mag_inc, mag_dec;
    assign mag_inc = (mag >= 4'(MAX_DX)) ? 4'(MAX_DX) : mag + 4'sd1;
    assign mag_dec = (mag > 4'sd1) ? mag - 4'sd1 : 4'sd1;
`endif

    // Wall and paddle directions are absolute; later rules override earlier ones
    always_comb begin
        b_dx    = dx;
        b_dy_dn = dy_dn;
        if (xe <= CW'(FIELD_LEFT))                     b_dx = mag;
        if (xe + CW'(BALL_SIZE - 1) >= CW'(FIELD_RIGHT)) b_dx = -mag;
        if (ye <= CW'(FIELD_TOP))                      b_dy_dn = 1'b1;
        if (b_dy_dn && (ye + CW'(BALL_SIZE) == CW'(PADDLE_Y)) &&
            (xe + CW'(BALL_SIZE - 1) >= pe) && (xe <= pe + CW'(PADDLE_W - 1))) begin
            b_dy_dn = 1'b0;
`ifdef BALL_PADDLE_ANGLE_EN
            if (cx < pe + CW'(PADDLE_W / 3))          b_dx = -mag_inc;
            else if (cx >= pe + CW'(2 * PADDLE_W / 3)) b_dx = mag_inc;
            else                                      b_dx = b_dx[3] ? -mag_dec : mag_dec;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            x         <= COORD_W'(START_X);
            y         <= COORD_W'(START_Y);
            dx        <= 4'sd1;
            dy_dn     <= 1'b0;
            delay     <= '0;
            idx       <= '0;
            hit_seen  <= 1'b0;
            hit_valid <= 1'b0;
            hit_idx   <= '0;
            lost      <= 1'b0;
        end else begin
            hit_valid <= 1'b0;
            case (state)
                S_IDLE: if (start) state <= S_WAIT;
                S_WAIT: begin
                    if (delay >= delay_done) begin
                        x        <= x_step;
                        y        <= y_step;
                        delay    <= '0;
                        idx      <= '0;
                        hit_seen <= 1'b0;
                        state    <= S_SCAN;
                    end else begin
                        delay <= delay + 1'b1;
                    end
                end
                S_SCAN: begin
                    if (overlap && !hit_seen) begin
                        hit_seen  <= 1'b1;
                        hit_valid <= 1'b1;
                        hit_idx   <= idx;
                        if (centre_in) dy_dn <= ~dy_dn;
                        else           dx    <= -dx;
                    end
                    if (idx == IDX_W'(NUM_BRICKS - 1)) state <= S_BOUNCE;
                    else                               idx   <= idx + 1'b1;
                end
                S_BOUNCE: begin
                    dx    <= b_dx;
                    dy_dn <= b_dy_dn;
                    if (bottom) begin
                        lost  <= 1'b1;
                        state <= S_LOST;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_LOST: begin
                    if (start) begin
                        x     <= COORD_W'(START_X);
                        y     <= COORD_W'(START_Y);
                        dx    <= 4'sd1;
                        dy_dn <= 1'b0;
                        delay <= '0;
                        lost  <= 1'b0;
                        state <= S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/ball_engine.md
# ball_engine

Parametrised ball-motion and collision engine for the brick-breaker game core; successor to the fixed six-brick ball block. It steps the ball at a programmable rate, scans an arbitrary number of bricks sequentially (one brick per cycle), reflects off walls, paddle and bricks, and reports each brick hit as a one-cycle indexed pulse. It sits between the paddle/brick-map logic and the VGA renderer, and drives the ball coordinates.

## Interface

- NUM_BRICKS, 8, number of bricks scanned; IDX_W = max(1, clog2(NUM_BRICKS)) is derived
- COORD_W, 10, coordinate width (unsigned)
- DELAY_W, 25, width of the step-delay counter
- BALL_SIZE, 20, ball edge length in pixels
- BRICK_W / BRICK_H, 58 / 20, brick size in pixels
- PADDLE_W / PADDLE_Y, 75 / 458, paddle width and paddle top row
- FIELD_LEFT / FIELD_RIGHT / FIELD_TOP / FIELD_BOTTOM, 134 / 504 / 0 / 478, playfield bounds
- START_X / START_Y, 309 / 438, serve position
- MAX_DX, 5, maximum horizontal speed magnitude (at most 7)

Ports:

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  serve request, sampled in IDLE and LOST
- delay_done  in  DELAY_W  idle cycles between steps
- paddle_x  in  COORD_W  paddle left edge
- brick_x / brick_y  in  NUM_BRICKS*COORD_W  packed brick origins; brick i occupies bits [i*COORD_W +: COORD_W]
- bricks_exist  in  NUM_BRICKS  per-brick live mask
- x / y  out  COORD_W  ball top-left corner
- hit_valid  out  1  one-cycle brick-hit pulse
- hit_idx  out  IDX_W  index of the hit brick; valid while hit_valid is high
- lost  out  1  ball passed the bottom edge

## Operation

- Velocity: dx is signed 4-bit, with magnitude 1..MAX_DX; dy is ±1.
- All comparisons use COORD_W+1 bits, so no sum wraps. x+dx saturates to the range 0..2^COORD_W-1.
- IDLE: x=START_X, y=START_Y, dx=+1, dy=-1, delay=0. start=1 → WAIT.
- WAIT: if delay >= delay_done, apply x+=dx and y+=dy, clear delay, set idx=0 and → SCAN. Otherwise increment delay.
- SCAN: evaluates brick idx in one cycle, then idx++. After idx = NUM_BRICKS-1 → BOUNCE.
  - Overlap requires bricks_exist[idx], x <= bx+BRICK_W-1, x+BALL_SIZE-1 >= bx, y <= by+BRICK_H-1 and y+BALL_SIZE-1 >= by.
  - Only the first (lowest-index) overlap per step is acted on; later overlaps in the same step are ignored.
  - On that hit: if ball centre x+BALL_SIZE/2 lies within bx..bx+BRICK_W-1, flip dy; otherwise flip dx. Issue hit_valid/hit_idx.
  - Brick inputs are sampled live at the cycle that evaluates each index.
- BOUNCE: directions are set absolutely (not toggled), in this order, with later rules overriding earlier ones:
  - x <= FIELD_LEFT → dx positive.
  - x+BALL_SIZE-1 >= FIELD_RIGHT → dx negative.
  - y <= FIELD_TOP → dy=+1.
  - Paddle hit: dy=+1, y+BALL_SIZE = PADDLE_Y, x+BALL_SIZE-1 >= paddle_x and x <= paddle_x+PADDLE_W-1 → dy=-1 (see Configuration).
  - y+BALL_SIZE-1 >= FIELD_BOTTOM → LOST. Otherwise → WAIT.
- LOST: lost=1 and the ball is frozen. start=1 reloads the serve state (as in IDLE), clears lost and → WAIT.

## Timing

- Reset values: state IDLE, x=START_X, y=START_Y, hit_valid=0, hit_idx=0, lost=0, delay=0, dx=+1, dy=-1.
- Step period is (delay_done+1) + NUM_BRICKS + 1 cycles; 10 cycles at delay_done=0 with the defaults.
- x and y change only on the WAIT exit edge and are stable for the rest of the step.
- hit_valid is registered: it is high for exactly one cycle, the cycle after the detecting SCAN cycle. At most one pulse per step.
- lost rises on the edge that enters LOST and falls on the edge that leaves it.
- Reset asserted mid-step forces all reset values immediately; a partial scan is discarded.
- start is ignored outside IDLE and LOST.

## Configuration

- BALL_PADDLE_ANGLE_EN defined: a paddle hit also reshapes dx according to the paddle third the ball centre lands on.
  - Left third: dx = -min(|dx|+1, MAX_DX).
  - Centre third: |dx| = max(|dx|-1, 1), sign kept.
  - Right third: dx = +min(|dx|+1, MAX_DX).
- BALL_PADDLE_ANGLE_EN undefined: a paddle hit changes only dy; dx is unchanged.

## Test plan

- Reset, then start=1 with delay_done=0 → x=309, y=438 in IDLE; first step x=310, y=437; steps repeat every 10 cycles; hit_valid stays 0.
- Ball at x=484, dx=+1 → step to x=485, BOUNCE sets dx=-1, next step x=484. Mirror check at FIELD_LEFT=134.
- Brick 0 at (300,200) live, ball at x=310 moving up reaching y=219 → hit_valid pulses once with hit_idx=0, dy becomes +1; with bricks_exist[0]=0 → no pulse.
- Bricks 2 and 5 both overlapping in one step → single pulse with hit_idx=2.
- Ball descending with paddle_x far away → at y=459, lost=1 and x/y frozen; start=1 → x=309, y=438, lost=0, motion resumes.
- Ball reaching y=438 (dy=+1, dx=+1), paddle_x=305 (centre in left third) → dy=-1 and dx=-2 with BALL_PADDLE_ANGLE_EN; dy=-1 and dx=+1 without it.
